// File: rtl/tut4_verilog_regincr_reg_decr_pipe_if.sv
// ---------------------------------------------------------------------------
// tut4_verilog_regincr_reg_decr_pipe_if
// Valid/ready bundle for the decrement pipeline: one input channel carrying
// the operand and one output channel carrying the result and underflow flag.
//
// Signals:
//   in_val     producer -> pipe   in_msg is valid
//   in_rdy     pipe -> producer   pipe accepts in_msg this cycle
//   in_msg     producer -> pipe   operand (p_nbits)
//   out_val    pipe -> consumer   out_msg/out_uflow are valid
//   out_rdy    consumer -> pipe   consumer accepts out_msg this cycle
//   out_msg    pipe -> consumer   result (p_nbits)
//   out_uflow  pipe -> consumer   result wrapped below zero
//
// Modports:
//   master  environment side (drives in_*, consumes out_*)
//   slave   pipeline side
// ---------------------------------------------------------------------------
interface tut4_verilog_regincr_reg_decr_pipe_if #(
  parameter int p_nbits = 8
);
  logic               in_val;
  logic               in_rdy;
  logic [p_nbits-1:0] in_msg;
  logic               out_val;
  logic               out_rdy;
  logic [p_nbits-1:0] out_msg;
  logic               out_uflow;

  modport master (
    output in_val, in_msg, out_rdy,
    input  in_rdy, out_val, out_msg, out_uflow
  );

  modport slave (
    input  in_val, in_msg, out_rdy,
    output in_rdy, out_val, out_msg, out_uflow
  );
endinterface

// File: rtl/tut4_verilog_regincr_reg_decr_pipe.sv
// ---------------------------------------------------------------------------
// tut4_verilog_regincr_reg_decr_pipe
// Two-stage valid/ready pipeline that subtracts the constant p_decr from each
// input (modulo 2^p_nbits) and flags results that wrapped below zero.
// S1 registers the operand; S2 registers the difference and the borrow.
// Stalls propagate combinationally from out_rdy so the pipe runs at full
// throughput and empty stages fill regardless of downstream state.
//
// Ports:
//   clk    clock, all state on posedge
//   reset  synchronous active-low reset (clears valid bits and count)
//   bus    valid/ready bundle, slave view
//   count  number of completed output transfers, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module tut4_verilog_regincr_reg_decr_pipe #(
  parameter int          p_nbits = 8,
  parameter int unsigned p_decr  = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  tut4_verilog_regincr_reg_decr_pipe_if.slave  bus,
  output logic [15:0]                          count
);

  // One extra bit so the MSB of the difference is the borrow.
  localparam logic [p_nbits:0] c_decr = (p_nbits+1)'(p_decr);

  logic               s1_val_q,   s1_val_d;
  logic [p_nbits-1:0] s1_data_q,  s1_data_d;
  logic               s2_val_q,   s2_val_d;
  logic [p_nbits-1:0] s2_data_q,  s2_data_d;
  logic               s2_uflow_q, s2_uflow_d;
  logic [15:0]        count_q,    count_d;

  logic               s1_adv;
  logic               s2_adv;
  logic               in_xfer;
  logic               out_xfer;
  logic               load_s2;
  logic [p_nbits:0]   diff;

  always_comb begin
    s2_adv   = !s2_val_q || bus.out_rdy;
    s1_adv   = !s1_val_q || s2_adv;
    in_xfer  = s1_adv && bus.in_val;
    out_xfer = s2_val_q && bus.out_rdy;
    load_s2  = s2_adv && s1_val_q;
    diff     = {1'b0, s1_data_q} - c_decr;

    // A stage that advances takes whatever sits behind it, valid or not,
    // which also clears its valid bit when nothing follows.
    s1_val_d   = s1_adv ? bus.in_val : s1_val_q;
    s1_data_d  = in_xfer ? bus.in_msg : s1_data_q;
    s2_val_d   = s2_adv ? s1_val_q : s2_val_q;
    s2_data_d  = load_s2 ? diff[p_nbits-1:0] : s2_data_q;
    s2_uflow_d = load_s2 ? diff[p_nbits] : s2_uflow_q;

    count_d = count_q;
    if (out_xfer && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_val_q <= 1'b0;
      s2_val_q <= 1'b0;
      count_q  <= 16'd0;
    end else begin
      s1_val_q <= s1_val_d;
      s2_val_q <= s2_val_d;
      count_q  <= count_d;
    end
  end

  // Data is qualified by the valid bits, so it needs no reset.
  always_ff @(posedge clk) begin
    s1_data_q  <= s1_data_d;
    s2_data_q  <= s2_data_d;
    s2_uflow_q <= s2_uflow_d;
  end

  assign bus.in_rdy    = s1_adv;
  assign bus.out_val   = s2_val_q;
  assign bus.out_msg   = s2_data_q;
  assign bus.out_uflow = s2_uflow_q;
  assign count         = count_q;

endmodule
